// File: rtl/branch_pkg.sv
// Shared encodings for the sequential branch comparator: funct3 codes, FSM states
// and small funct3 decode helpers.
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic logic is_illegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    function automatic logic is_signed(input logic [2:0] f3);
        return f3[2:1] == 2'b10;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned comparison of one operand slice.
module cmp_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ne,
    output logic         lt
);

    assign ne = (a != b);
    assign lt = (a < b);

endmodule

// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch-condition evaluator: scans the operands one slice per cycle,
// MSB slice first, and resolves the funct3 branch type with valid/ready handshakes.
module branch_cmp_seq
    import branch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SLICE      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            illegal
);

    localparam int unsigned NSLICE = XLEN / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    state_t            r_state;
    logic [XLEN-1:0]   r_a, r_b;
    logic [2:0]        r_f3;
    logic [IDXW-1:0]   r_idx;
    logic              r_diff, r_lt;
    logic              r_out_valid, r_taken, r_illegal;

    logic [XLEN-1:0]   w_flip;
    logic [SLICE-1:0]  w_sa, w_sb;
    logic              w_ne, w_lt;
    logic              w_diff_new, w_lt_new, w_last, w_taken;

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
    assign w_flip = is_signed(funct3) ? {1'b1, {(XLEN-1){1'b0}}} : '0;

    assign w_sa = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_sb = r_b[int'(r_idx) * SLICE +: SLICE];

    cmp_slice #(
        .W (SLICE)
    ) u_cmp_slice (
        .a  (w_sa),
        .b  (w_sb),
        .ne (w_ne),
        .lt (w_lt)
    );

    // Only the first (most significant) differing slice decides the ordering.
    assign w_diff_new = r_diff | w_ne;
    assign w_lt_new   = r_diff ? r_lt : w_lt;
    assign w_last     = (w_ne && EARLY_EXIT) || (r_idx == '0);

    always_comb begin
        w_taken = 1'b0;
        case (r_f3)
            BEQ:        w_taken = !w_diff_new;
            BNE:        w_taken = w_diff_new;
            BLT, BLTU:  w_taken = w_diff_new && w_lt_new;
            BGE, BGEU:  w_taken = !(w_diff_new && w_lt_new);
            default:    w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_f3        <= '0;
            r_idx       <= IDX_TOP;
            r_diff      <= 1'b0;
            r_lt        <= 1'b0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= r1 ^ w_flip;
                        r_b    <= r2 ^ w_flip;
                        r_f3   <= funct3;
                        r_idx  <= IDX_TOP;
                        r_diff <= 1'b0;
                        r_lt   <= 1'b0;
                        if (is_illegal(funct3)) begin
                            r_state   <= DONE;
                            r_illegal <= 1'b1;
                            r_taken   <= 1'b0;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    r_diff <= w_diff_new;
                    r_lt   <= w_lt_new;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_taken     <= w_taken;
                        r_illegal   <= 1'b0;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                DONE: begin
                    // Illegal requests enter DONE straight from IDLE; valid follows a cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign taken     = r_taken;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq with a reference model feeding a result scoreboard.
module tb_branch_cmp_seq;

    typedef struct {
        logic taken;
        logic illegal;
        int   k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid_nx;
    logic [31:0] r1, r2;
    logic [2:0]  funct3;
    logic        flush, out_ready;
    logic        in_ready_ee, out_valid_ee, taken_ee, illegal_ee;
    logic        in_ready_nx, out_valid_nx, taken_nx, illegal_nx;
    logic        sel;
    logic        m_in_ready, m_ov, m_taken, m_illegal;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    branch_cmp_seq #(.XLEN(32), .SLICE(8), .EARLY_EXIT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_ee),
        .r1        (r1),
        .r2        (r2),
        .funct3    (funct3),
        .flush     (flush),
        .out_valid (out_valid_ee),
        .out_ready (out_ready),
        .taken     (taken_ee),
        .illegal   (illegal_ee)
    );

    branch_cmp_seq #(.XLEN(32), .SLICE(8), .EARLY_EXIT(1'b0)) dut_nx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_nx),
        .in_ready  (in_ready_nx),
        .r1        (r1),
        .r2        (r2),
        .funct3    (funct3),
        .flush     (flush),
        .out_valid (out_valid_nx),
        .out_ready (out_ready),
        .taken     (taken_nx),
        .illegal   (illegal_nx)
    );

    assign m_in_ready = sel ? in_ready_nx  : in_ready_ee;
    assign m_ov       = sel ? out_valid_nx : out_valid_ee;
    assign m_taken    = sel ? taken_nx     : taken_ee;
    assign m_illegal  = sel ? illegal_nx   : illegal_ee;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input bit ee);
        exp_t e;
        bit   found;
        e.illegal = 1'b0;
        e.taken   = 1'b0;
        case (f3)
            3'b000: e.taken = (a == b);
            3'b001: e.taken = (a != b);
            3'b100: e.taken = ($signed(a) <  $signed(b));
            3'b101: e.taken = ($signed(a) >= $signed(b));
            3'b110: e.taken = (a <  b);
            3'b111: e.taken = (a >= b);
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e.k = 1;
        end else if (!ee) begin
            e.k = 4;
        end else begin
            e.k   = 4;
            found = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                if (!found && (a[i*8 +: 8] != b[i*8 +: 8])) begin
                    e.k   = 4 - i;
                    found = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept at the next edge, then scramble the inputs so late changes would show up.
    task automatic accept(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input string tag);
        sel = s;
        @(negedge clk);
        check({tag, ":in_ready"}, m_in_ready, 1'b1);
        r1     = a;
        r2     = b;
        funct3 = f3;
        if (s) in_valid_nx = 1'b1;
        else   in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_valid_nx = 1'b0;
        r1          = $urandom;
        r2          = $urandom;
        funct3      = ~f3;
    endtask

    task automatic run_req(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input int hold, input string tag);
        exp_t e;
        int   cyc;
        sb.push_back(model(a, b, f3, !s));
        accept(s, a, b, f3, tag);
        cyc = 0;
        while (!m_ov && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        check_int({tag, ":latency"}, cyc, e.k);
        check({tag, ":taken"}, m_taken, e.taken);
        check({tag, ":illegal"}, m_illegal, e.illegal);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, m_ov, 1'b1);
            check({tag, ":hold_taken"}, m_taken, e.taken);
            check({tag, ":hold_in_ready"}, m_in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, m_ov, 1'b0);
        check({tag, ":idle_ready"}, m_in_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_valid_nx = 1'b0;
        r1          = '0;
        r2          = '0;
        funct3      = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        sel         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst:in_ready", in_ready_ee, 1'b0);
        check("rst:out_valid", out_valid_ee, 1'b0);
        check("rst:taken", taken_ee, 1'b0);
        check("rst:illegal", illegal_ee, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel:in_ready", in_ready_ee, 1'b1);

        run_req(1'b0, 32'h12345678, 32'h12345678, 3'b000, 0, "beq_eq");
        run_req(1'b1, 32'h80000000, 32'h00000000, 3'b001, 0, "bne_noexit");
        run_req(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, "blt_neg");
        run_req(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, "bltu");
        run_req(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b101, 0, "bge");
        run_req(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b111, 0, "bgeu");
        run_req(1'b0, 32'h00000100, 32'h000000FF, 3'b111, 0, "bgeu_s1");
        run_req(1'b0, 32'h00000100, 32'h000000FF, 3'b001, 0, "bne_s1");
        run_req(1'b0, 32'hDEADBEEF, 32'h01234567, 3'b010, 0, "ill_010");
        run_req(1'b0, 32'h00000000, 32'hFFFFFFFF, 3'b011, 0, "ill_011");
        run_req(1'b0, 32'h7FFFFFFF, 32'h80000000, 3'b101, 5, "bp_bge");
        run_req(1'b0, 32'h00000000, 32'h00000000, 3'b000, 0, "after_bp");

        // Flush in the second SCAN cycle; taken was left high by the previous request.
        accept(1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, "flush");
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush:out_valid", out_valid_ee, 1'b0);
        check("flush:in_ready", in_ready_ee, 1'b1);
        check("flush:taken", taken_ee, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_ee;
        end
        check("flush:never_valid", seen, 1'b0);

        // Reset mid-SCAN; illegal was left high by the preceding request.
        run_req(1'b0, 32'h0, 32'h0, 3'b010, 0, "pre_rst");
        accept(1'b0, 32'h11111111, 32'h11111111, 3'b000, "rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid:in_ready", in_ready_ee, 1'b0);
        check("rst_mid:out_valid", out_valid_ee, 1'b0);
        check("rst_mid:taken", taken_ee, 1'b0);
        check("rst_mid:illegal", illegal_ee, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_mid:ready_after", in_ready_ee, 1'b1);
        run_req(1'b0, 32'h00000005, 32'h00000009, 3'b110, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
